// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a single uart_tx serializer.
// A winner keeps the serializer until its last beat is accepted; an optional header carries its index.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int Word_len = 8,
    parameter bit HDR_EN   = 1'b1,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*Word_len-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [Word_len-1:0]          tx_data,
    output logic                         tx_data_valid,
    output logic                         tx_data_last,
    input  logic                         tx_data_ready,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;

    logic [IDW-1:0]       pick;
    logic                 found;
    int                   rot_idx;

    logic [NUM_REQ-1:0]   sel_oh;
    logic [Word_len-1:0]  g_data;
    logic                 g_valid;
    logic                 g_last;

    // Rotating search starting just after the previous owner, wrapping modulo NUM_REQ.
    always_comb begin
        pick    = last_grant_q;
        found   = 1'b0;
        rot_idx = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rot_idx = (int'(last_grant_q) + i) % NUM_REQ;
            if (!found && |(req_valid & (NUM_REQ'(1) << rot_idx))) begin
                found = 1'b1;
                pick  = IDW'(rot_idx);
            end
        end
    end

    always_comb begin
        sel_oh  = NUM_REQ'(1) << grant_q;
        g_data  = Word_len'(req_data >> (int'(grant_q) * Word_len));
        g_valid = |(req_valid & sel_oh);
        g_last  = |(req_last & sel_oh);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        tx_data       = '0;
        tx_data_valid = 1'b0;
        tx_data_last  = 1'b0;
        req_ready     = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = HDR_EN ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                tx_data       = Word_len'(grant_q);
                tx_data_valid = 1'b1;
                if (tx_data_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_data       = g_data;
                tx_data_valid = g_valid;
                tx_data_last  = g_valid & g_last;
                req_ready     = sel_oh & {NUM_REQ{tx_data_ready}};
                if (g_valid && g_last && tx_data_ready) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester models feed byte queues, serializer beats
// are collected and compared against an expected-beat scoreboard.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int WL = 8;

    typedef struct {
        logic [8:0] b;
        int         cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR*WL-1:0] req_data;
    logic [NR-1:0]    req_valid, req_last, req_ready;
    logic [WL-1:0]    tx_data;
    logic             tx_data_valid, tx_data_last, tx_data_ready;
    logic [1:0]       grant_id;
    logic             busy;

    logic [WL-1:0]    b_req_data;
    logic             b_req_valid, b_req_last, b_req_ready;
    logic [WL-1:0]    b_tx_data;
    logic             b_tx_valid, b_tx_last, b_txr;
    logic             b_grant_id;
    logic             b_busy;

    uart_tx_arbiter #(.NUM_REQ(NR), .Word_len(WL), .HDR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_last(tx_data_last),
        .tx_data_ready(tx_data_ready), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_REQ(1), .Word_len(WL), .HDR_EN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_data(b_req_data), .req_valid(b_req_valid), .req_last(b_req_last), .req_ready(b_req_ready),
        .tx_data(b_tx_data), .tx_data_valid(b_tx_valid), .tx_data_last(b_tx_last),
        .tx_data_ready(b_txr), .grant_id(b_grant_id), .busy(b_busy)
    );

    // requester byte stores: entry = {data, last}
    logic [8:0] rmem [NR][16];
    int         rlen [NR];
    int         rptr [NR];
    bit         en   [NR];
    logic [8:0] bmem [8];
    int         blen, bptr;

    logic [8:0] exp_a[$];
    obs_t       obs_a[$];
    obs_t       obs_b[$];

    int cyc;
    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            logic v;
            v = en[i] && (rptr[i] < rlen[i]);
            req_valid[i]         = v;
            req_data[i*WL +: WL] = v ? rmem[i][rptr[i]][8:1] : 8'h00;
            req_last[i]          = v ? rmem[i][rptr[i]][0] : 1'b0;
        end
        b_req_valid = (bptr < blen);
        b_req_data  = b_req_valid ? bmem[bptr][8:1] : 8'h00;
        b_req_last  = b_req_valid ? bmem[bptr][0] : 1'b0;
    endtask

    // One clock: sample handshakes at the falling edge, advance requester stores after the rising edge.
    task automatic tick();
        logic hs [NR];
        logic bhs;
        obs_t o;
        @(negedge clk);
        for (int i = 0; i < NR; i++) hs[i] = req_valid[i] & req_ready[i];
        bhs = b_req_valid & b_req_ready;
        if (tx_data_valid && tx_data_ready) begin
            o.b = {tx_data, tx_data_last}; o.cyc = cyc; obs_a.push_back(o);
        end
        if (b_tx_valid && b_txr) begin
            o.b = {b_tx_data, b_tx_last}; o.cyc = cyc; obs_b.push_back(o);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n) begin
            for (int i = 0; i < NR; i++) if (hs[i]) rptr[i]++;
            if (bhs) bptr++;
        end
        drive();
        #1;
    endtask

    task automatic push_a(input int r, input logic [7:0] d, input logic l);
        rmem[r][rlen[r]] = {d, l};
        rlen[r]++;
    endtask

    task automatic expect_a(input logic [7:0] d, input logic l);
        exp_a.push_back({d, l});
    endtask

    task automatic wait_obs(input int n, input string tag);
        int budget = 0;
        while (obs_a.size() < n && budget < 300) begin tick(); budget++; end
        chk({tag, " wait"}, 32'(obs_a.size() >= n), 32'd1);
    endtask

    task automatic drain_a(input string tag, output int first_cyc);
        int budget = 0;
        obs_t o;
        logic [8:0] e;
        first_cyc = -1;
        while (obs_a.size() < exp_a.size() && budget < 300) begin tick(); budget++; end
        chk({tag, " beats"}, obs_a.size(), exp_a.size());
        if (obs_a.size() > 0) first_cyc = obs_a[0].cyc;
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front();
            o = obs_a.pop_front();
            chk({tag, " beat"}, o.b, e);
        end
        exp_a.delete();
        obs_a.delete();
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        obs_a.delete();
        exp_a.delete();
    endtask

    initial begin
        int fc, ld, rel;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; tx_data_ready = 1'b1; b_txr = 1'b1;
        blen = 0; bptr = 0;
        for (int i = 0; i < NR; i++) begin rlen[i] = 0; rptr[i] = 0; en[i] = 1'b1; end
        drive();
        @(posedge clk);
        #2;
        tick();
        rst_n = 1'b1;
        chk("rst grant_id", grant_id, 0);
        chk("rst busy", busy, 0);
        chk("rst tx_valid", tx_data_valid, 0);
        chk("rst tx_last", tx_data_last, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst req_ready", req_ready, 0);
        chk("rst b grant_id", b_grant_id, 0);

        // single 3-byte packet from requester 0
        push_a(0, 8'hA1, 0); push_a(0, 8'hA2, 0); push_a(0, 8'hA3, 1);
        expect_a(8'h00, 0); expect_a(8'hA1, 0); expect_a(8'hA2, 0); expect_a(8'hA3, 1);
        ld = cyc; drive(); #1;
        drain_a("t1", fc);
        chk("t1 latency", fc, ld + 1);
        chk("t1 busy after last", busy, 0);
        chk("t1 grant_id", grant_id, 0);

        // all four requesting together, then 0 vs 3 rotation
        reset_seq();
        push_a(0, 8'h10, 1); push_a(1, 8'h20, 1); push_a(2, 8'h30, 1); push_a(3, 8'h40, 1);
        expect_a(8'h00, 0); expect_a(8'h10, 1); expect_a(8'h01, 0); expect_a(8'h20, 1);
        expect_a(8'h02, 0); expect_a(8'h30, 1); expect_a(8'h03, 0); expect_a(8'h40, 1);
        drive(); #1;
        drain_a("t2 rr", fc);
        push_a(3, 8'h41, 1); push_a(0, 8'h11, 1);
        expect_a(8'h00, 0); expect_a(8'h11, 1); expect_a(8'h03, 0); expect_a(8'h41, 1);
        drive(); #1;
        drain_a("t2 wrap", fc);
        chk("t2 grant_id", grant_id, 3);

        // requester 2 stalls mid-packet while requester 1 waits
        push_a(2, 8'hC1, 0); push_a(2, 8'hC2, 0); push_a(2, 8'hC3, 1);
        expect_a(8'h02, 0); expect_a(8'hC1, 0); expect_a(8'hC2, 0); expect_a(8'hC3, 1);
        expect_a(8'h01, 0); expect_a(8'hB1, 1);
        drive(); #1;
        wait_obs(2, "t3");
        en[2] = 1'b0;
        push_a(1, 8'hB1, 1);
        drive(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3 stall tx_valid", tx_data_valid, 0);
            chk("t3 stall grant_id", grant_id, 2);
            chk("t3 stall ready1", req_ready[1], 0);
            tick();
        end
        en[2] = 1'b1;
        drive(); #1;
        drain_a("t3", fc);

        // serializer back-pressure during the header
        tx_data_ready = 1'b0;
        push_a(3, 8'hD1, 1);
        expect_a(8'h03, 0); expect_a(8'hD1, 1);
        drive(); #1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("t4 hdr hold", {busy, tx_data_valid, tx_data, grant_id}, {1'b1, 1'b1, 8'h03, 2'd3});
            tick();
        end
        tx_data_ready = 1'b1;
        rel = cyc;
        #1;
        drain_a("t4", fc);
        chk("t4 accept cycle", fc, rel);

        // asynchronous reset on the second data beat
        push_a(1, 8'hE1, 0); push_a(1, 8'hE2, 0); push_a(1, 8'hE3, 1);
        expect_a(8'h01, 0); expect_a(8'hE1, 0);
        drive(); #1;
        wait_obs(2, "t5");
        chk("t5 pre tx", {tx_data_valid, tx_data}, {1'b1, 8'hE2});
        rst_n = 1'b0;
        #1;
        chk("t5 async tx_valid", tx_data_valid, 0);
        chk("t5 async req_ready", req_ready, 0);
        chk("t5 async busy", busy, 0);
        chk("t5 async grant_id", grant_id, 0);
        drain_a("t5 pre", fc);
        rlen[1] = rptr[1];
        tick();
        tick();
        rst_n = 1'b1;
        push_a(1, 8'h61, 1); push_a(0, 8'hF1, 1);
        expect_a(8'h00, 0); expect_a(8'hF1, 1); expect_a(8'h01, 0); expect_a(8'h61, 1);
        drive(); #1;
        drain_a("t5 post", fc);

        // single requester, no header, back-to-back 2-byte packets
        bmem[0] = {8'h51, 1'b0}; bmem[1] = {8'h52, 1'b1};
        bmem[2] = {8'h71, 1'b0}; bmem[3] = {8'h72, 1'b1};
        blen = 4;
        ld = cyc; drive(); #1;
        begin
            int budget = 0;
            while (obs_b.size() < 4 && budget < 100) begin
                tick(); budget++;
                if (b_busy) chk("t6 grant_id", b_grant_id, 0);
            end
        end
        chk("t6 beats", obs_b.size(), 4);
        if (obs_b.size() == 4) begin
            chk("t6 b0", {obs_b[0].b, 8'(obs_b[0].cyc - ld)}, {9'h0A2, 8'd1});
            chk("t6 b1", {obs_b[1].b, 8'(obs_b[1].cyc - ld)}, {9'h0A5, 8'd2});
            chk("t6 b2", {obs_b[2].b, 8'(obs_b[2].cyc - ld)}, {9'h0E2, 8'd4});
            chk("t6 b3", {obs_b[3].b, 8'(obs_b[3].cyc - ld)}, {9'h0E5, 8'd5});
        end
        chk("t6 busy after", b_busy, 0);
        chk("t6 no stray A beats", obs_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte-stream requesters. It sits directly upstream of `uart_tx`, driving that block's `tx_data`/`tx_data_valid`/`tx_data_last` and consuming `tx_data_ready`. A granted requester owns the serializer until its `last` beat is accepted. An optional header byte carrying the requester index precedes each packet so the far end can demultiplex.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 1–16.
- `Word_len`, 8: byte width; must be ≥ `IDW`.
- `HDR_EN`, 1: 1 = send a header byte before every packet; 0 = no header.
- `IDW`, derived as max(1, $clog2(`NUM_REQ`)): width of the requester index.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_data` input `NUM_REQ*Word_len`: requester i uses bits [i*`Word_len` +: `Word_len`].
- `req_valid` input `NUM_REQ`: per-requester byte valid.
- `req_last` input `NUM_REQ`: per-requester final-byte-of-packet flag, qualified by `req_valid`.
- `req_ready` output `NUM_REQ`: per-requester accept; at most one bit high at a time.
- `tx_data` output `Word_len`: byte to the serializer.
- `tx_data_valid` output 1: byte valid to the serializer.
- `tx_data_last` output 1: final byte of the current packet.
- `tx_data_ready` input 1: serializer can accept a byte.
- `grant_id` output `IDW`: index of the current or most recent owner.
- `busy` output 1: high in HDR and DATA states.

## Operation
- Handshake: a beat transfers on any cycle where `valid` and `ready` are both high.
- State machine states: IDLE, HDR, DATA.
- IDLE:
  - All `req_ready` are 0; `tx_data_valid` is 0.
  - If any `req_valid` is high, select the first requester with valid set, searching from `last_grant`+1 upward with wrap-around.
  - Register the selection in `grant_id`.
  - Next state is HDR if `HDR_EN`=1, otherwise DATA.
- HDR:
  - `tx_data` = `grant_id` zero-extended to `Word_len`; `tx_data_valid`=1; `tx_data_last`=0.
  - All `req_ready` are 0.
  - On handshake, go to DATA.
- DATA, combinational pass-through from the granted requester g:
  - `tx_data`=`req_data`[g], `tx_data_valid`=`req_valid`[g], `tx_data_last`=`req_valid`[g]&`req_last`[g].
  - `req_ready`[g]=`tx_data_ready`; all other `req_ready` bits are 0.
  - On a handshake with `last` high: set `last_grant` ← g and return to IDLE.
- Grant persistence:
  - The grant is held for the whole packet.
  - If `req_valid`[g] drops mid-packet, `tx_data_valid` drops with it and the grant is kept. There is no timeout.
- Ungranted requesters are never acknowledged. Their valid/data must stay stable until they are granted.
- `last_grant` is internal and `IDW` bits wide; wrap-around is modulo `NUM_REQ`, not modulo 2^`IDW`.
- `NUM_REQ`=1: arbitration is trivial and `grant_id` is always 0.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - State = IDLE, `last_grant`=`NUM_REQ`-1, so requester 0 has first priority.
  - Outputs: `grant_id`=0, `busy`=0, `tx_data_valid`=0, `tx_data_last`=0, `tx_data`=0, `req_ready`=0.
- Reset mid-packet: all outputs return to the reset values immediately (asynchronously). The partial packet is dropped and no `last` is emitted.
- Arbitration latency: exactly 1 cycle in IDLE. With valid present, the first HDR (or DATA) cycle is the cycle after valid is seen.
- Inter-packet gap: minimum 1 IDLE cycle after the `last` handshake, even if the same or another requester is ready.
- `busy` and `grant_id` are registered. `tx_*` and `req_ready` are combinational from state, `grant_id`, and requester inputs; there are no registers in the data path.
- Simultaneous requests in IDLE: exactly one winner per the rotation rule. Requests arriving during HDR/DATA wait for IDLE.
- A single-beat packet (valid & last on the first DATA beat) is legal. It takes 1 DATA cycle when `tx_data_ready`=1.

## Test plan
- Reset, then `req_valid`=4'b0001 with a 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), `HDR_EN`=1 → serializer receives 0x00,0xA1,0xA2,0xA3; `tx_data_last` high only on 0xA3; `busy` falls 1 cycle after.
- All four requesters valid with 1-byte packets 0x10,0x20,0x30,0x40 → grant order 0,1,2,3 and headers 0x00..0x03; then requester 0 again is granted ahead of a re-requesting requester 3.
- Requester 2 mid-packet drops `req_valid` for 5 cycles while requester 1 is valid → `tx_data_valid`=0 for those 5 cycles, `grant_id` stays 2, `req_ready`[1] stays 0.
- `tx_data_ready` held low for 20 cycles during HDR → header byte held stable, no state change; accepted on the first ready cycle.
- `rst_n` pulsed low during the DATA beat of the 2nd byte of a packet → `tx_data_valid`, `req_ready`, and `busy` go to 0 with no clock edge; after release, requester 0 wins first.
- `HDR_EN`=0, `NUM_REQ`=1, back-to-back 2-byte packets → bytes pass through with no header and exactly one idle cycle between packets.
